// File: rtl/query_patch_mem_ctrl.sv
// Query patch memory controller: loads N patches into a dual-port memory, then streams them back out.
// Optional port-0 readback path is compiled in with `define QPM_READBACK_EN.
module query_patch_mem_ctrl #(
   parameter int DATA_WIDTH = 11,
   parameter int PATCH_SIZE = 5,
   parameter int ADDR_WIDTH = 9,
   parameter int DEPTH      = 512
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic [ADDR_WIDTH:0]                num_patches,
   output logic                               busy,
   output logic                               done,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [DATA_WIDTH*PATCH_SIZE-1:0]   in_patch,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [DATA_WIDTH*PATCH_SIZE-1:0]   out_patch,
   input  logic                               rb_valid,
   output logic                               rb_ready,
   input  logic [ADDR_WIDTH-1:0]              rb_addr,
   output logic                               rb_data_valid,
   output logic [DATA_WIDTH*PATCH_SIZE-1:0]   rb_data,
   output logic                               csb0,
   output logic                               web0,
   output logic [ADDR_WIDTH-1:0]              addr0,
   output logic [DATA_WIDTH*PATCH_SIZE-1:0]   wpatch0,
   input  logic [DATA_WIDTH*PATCH_SIZE-1:0]   rpatch0,
   output logic                               csb1,
   output logic [ADDR_WIDTH-1:0]              addr1,
   input  logic [DATA_WIDTH*PATCH_SIZE-1:0]   rpatch1
);

   localparam int PW = DATA_WIDTH * PATCH_SIZE;
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]         N_MAX    = CW'(DEPTH);
   localparam logic [CW-1:0]         CNT_ONE  = CW'(1'b1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         n_q, n_d;
   logic [CW-1:0]         raddr_q, raddr_d;
   logic [CW-1:0]         ocnt_q, ocnt_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic                  inflight_q, inflight_d;
   logic [PW-1:0]         fifo_q [2];
   logic                  wptr_q, rptr_q;
   logic [1:0]            fcnt_q, fcnt_d;

   logic                  load_acc_s, pop_s, push_s, issue_s, rb_acc_s;
   logic [CW-1:0]         n_clamp_s, n_last_s;
   logic [2:0]            occ_s;

   assign n_clamp_s  = (num_patches > N_MAX) ? N_MAX : num_patches;
   assign n_last_s   = n_q - CNT_ONE;
   assign load_acc_s = (state_q == ST_LOAD) && in_valid;
   assign pop_s      = (fcnt_q != 2'd0) && out_ready;
   assign push_s     = inflight_q;
   // Slots already committed after this cycle's pop: buffered entries plus the read still returning.
   assign occ_s      = {1'b0, fcnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
   assign issue_s    = (state_q == ST_STREAM) && (raddr_q < n_q) && (occ_s < 3'd2);

`ifdef QPM_READBACK_EN
   logic rb_ready_q, rb_dv_q;

   assign rb_acc_s      = rb_valid && rb_ready_q;
   assign rb_ready      = rb_ready_q;
   assign rb_data_valid = rb_dv_q;
   assign rb_data       = rb_dv_q ? rpatch0 : {PW{1'b0}};

   // Readback grant tracks the next state so LOAD writes always own port 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         rb_ready_q <= 1'b0;
         rb_dv_q    <= 1'b0;
      end else begin
         rb_ready_q <= (state_d != ST_LOAD);
         rb_dv_q    <= rb_acc_s;
      end
   end
`else
   logic unused_rb_s;

   assign unused_rb_s   = ^{rb_valid, rb_addr, rpatch0};
   assign rb_acc_s      = 1'b0;
   assign rb_ready      = 1'b0;
   assign rb_data_valid = 1'b0;
   assign rb_data       = {PW{1'b0}};
`endif

   // Next-state logic for the job FSM and its counters.
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      waddr_d    = waddr_q;
      raddr_d    = raddr_q;
      ocnt_d     = ocnt_q;
      inflight_d = issue_s;
      fcnt_d     = fcnt_q + {1'b0, push_s} - {1'b0, pop_s};
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               n_d     = n_clamp_s;
               waddr_d = {ADDR_WIDTH{1'b0}};
               raddr_d = {CW{1'b0}};
               ocnt_d  = {CW{1'b0}};
               state_d = (n_clamp_s == {CW{1'b0}}) ? ST_DONE : ST_LOAD;
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            if (load_acc_s) begin
               if ({1'b0, waddr_q} == n_last_s) begin
                  state_d = ST_STREAM;
               end else begin
                  waddr_d = waddr_q + ADDR_ONE;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_STREAM: begin
            if (issue_s) begin
               raddr_d = raddr_q + CNT_ONE;
            end else begin
               raddr_d = raddr_q;
            end
            if (pop_s) begin
               ocnt_d = ocnt_q + CNT_ONE;
               if (ocnt_q == n_last_s) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = state_q;
               end
            end else begin
               ocnt_d = ocnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and the 2-entry output FIFO; reset drops any read still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         n_q        <= {CW{1'b0}};
         waddr_q    <= {ADDR_WIDTH{1'b0}};
         raddr_q    <= {CW{1'b0}};
         ocnt_q     <= {CW{1'b0}};
         inflight_q <= 1'b0;
         fifo_q[0]  <= {PW{1'b0}};
         fifo_q[1]  <= {PW{1'b0}};
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
         fcnt_q     <= 2'd0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         waddr_q    <= waddr_d;
         raddr_q    <= raddr_d;
         ocnt_q     <= ocnt_d;
         inflight_q <= inflight_d;
         fcnt_q     <= fcnt_d;
         if (push_s) begin
            fifo_q[wptr_q] <= rpatch1;
            wptr_q         <= ~wptr_q;
         end
         if (pop_s) begin
            rptr_q <= ~rptr_q;
         end
      end
   end

   assign busy      = (state_q == ST_LOAD) || (state_q == ST_STREAM);
   assign done      = (state_q == ST_DONE);
   assign in_ready  = (state_q == ST_LOAD);
   assign out_valid = (fcnt_q != 2'd0);
   assign out_patch = fifo_q[rptr_q];
   assign csb1      = ~issue_s;
   assign addr1     = issue_s ? raddr_q[ADDR_WIDTH-1:0] : {ADDR_WIDTH{1'b0}};

   // Port 0 mux: LOAD writes first, readback only when granted, idle otherwise.
   always_comb begin
      csb0    = 1'b1;
      web0    = 1'b1;
      addr0   = {ADDR_WIDTH{1'b0}};
      wpatch0 = {PW{1'b0}};
      if (load_acc_s) begin
         csb0    = 1'b0;
         web0    = 1'b0;
         addr0   = waddr_q;
         wpatch0 = in_patch;
      end else if (rb_acc_s) begin
         csb0  = 1'b0;
         addr0 = rb_addr;
      end else begin
         csb0 = 1'b1;
      end
   end

endmodule

// File: doc/query_patch_mem_ctrl.md
QUERY_PATCH_MEM_CTRL -- requirements
Module: query_patch_mem_ctrl

Interface
REQ-001 SHALL have these parameters (name, default, meaning): DATA_WIDTH, 11, bits per patch element; PATCH_SIZE, 5, elements per patch; ADDR_WIDTH, 9, query memory address bits; DEPTH, 512, query memory entries.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with these ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, pulse that begins a load/stream job.
- num_patches, in, ADDR_WIDTH+1, job length, sampled on start.
- busy, out, 1, high in LOAD or STREAM.
- done, out, 1, high while in DONE.
- in_valid / in_ready, in / out, 1 / 1, incoming query patch handshake.
- in_patch, in, DATA_WIDTH*PATCH_SIZE, incoming query patch.
- out_valid / out_ready, out / in, 1 / 1, outgoing patch stream handshake.
- out_patch, out, DATA_WIDTH*PATCH_SIZE, outgoing query patch.
- rb_valid / rb_ready, in / out, 1 / 1, port-0 readback request handshake.
- rb_addr, in, ADDR_WIDTH, readback address.
- rb_data_valid, out, 1, readback data qualifier.
- rb_data, out, DATA_WIDTH*PATCH_SIZE, readback data.
- csb0 / web0, out / out, 1 / 1, memory port 0 chip select and write enable, both active low.
- addr0, out, ADDR_WIDTH, memory port 0 address.
- wpatch0, out, DATA_WIDTH*PATCH_SIZE, memory port 0 write data.
- rpatch0, in, DATA_WIDTH*PATCH_SIZE, memory port 0 read data.
- csb1, out, 1, memory port 1 chip select, active low.
- addr1, out, ADDR_WIDTH, memory port 1 address.
- rpatch1, in, DATA_WIDTH*PATCH_SIZE, memory port 1 read data.

Function
REQ-003 SHALL implement the FSM states IDLE, LOAD, STREAM and DONE.
REQ-004 SHALL, on start in IDLE or DONE, latch N=num_patches and go to LOAD; SHALL go directly to DONE when N=0; SHALL clamp N>DEPTH to DEPTH; SHALL ignore start in LOAD or STREAM.
REQ-005 SHALL drive in_ready=1 only in LOAD, with in_ready never depending on in_valid.
REQ-006 SHALL, on each LOAD accept (in_valid&in_ready), drive csb0=0, web0=0, addr0=waddr and wpatch0=in_patch in the same cycle, then increment waddr.
REQ-007 SHALL go from LOAD to STREAM in the cycle after the accept with waddr=N-1; waddr SHALL never wrap past DEPTH-1.
REQ-008 SHALL use a memory read latency of 1 cycle on both ports: data is valid on rpatch0/rpatch1 the cycle after csb is low.
REQ-009 SHALL, in STREAM, issue port-1 reads at raddr=0..N-1 in order, driving csb1=0 and addr1=raddr, and buffer the returned data in a 2-entry FIFO that drives out_valid/out_patch.
REQ-010 SHALL issue a port-1 read only when (fifo_count + inflight - pop_this_cycle) < 2, so the FIFO never overflows and sustains 1 patch/cycle while out_ready=1.
REQ-011 SHALL hold out_patch stable while out_valid=1 and out_ready=0.
REQ-012 SHALL go from STREAM to DONE the cycle after the Nth out handshake; done SHALL stay high until the next start or reset.
REQ-013 SHALL arbitrate port 0 with LOAD writes at fixed priority: rb_ready=0 in LOAD and rb_ready=1 otherwise.
REQ-014 SHALL, on a readback accept, drive csb0=0, web0=1 and addr0=rb_addr, then the next cycle assert rb_data_valid=1 for one cycle with rb_data=rpatch0.
REQ-015 SHALL keep csb0=1, web0=1 and csb1=1 in every cycle with no access.
REQ-016 SHALL allow a readback to proceed in the same cycle as a port-1 stream read, since the ports are independent.

Reset
REQ-017 SHALL, on rst=1 at a clock edge, set: state=IDLE; waddr=0, raddr=0, N=0; FIFO empty and inflight cleared; busy=0, done=0, in_ready=0, out_valid=0, rb_ready=0, rb_data_valid=0; csb0=1, web0=1, csb1=1; addr0, addr1, wpatch0, out_patch and rb_data=0.
REQ-018 SHALL discard any read in flight when reset asserts mid-job, with no out_valid or rb_data_valid in the cycle after reset.

Configuration
REQ-019 SHALL compile the readback path in only when macro QPM_READBACK_EN is defined: REQ-013, REQ-014 and REQ-016 are active.
REQ-020 SHALL, without QPM_READBACK_EN, keep the rb_* ports present, tie rb_ready=0, rb_data_valid=0 and rb_data=0, ignore rb_valid and rb_addr, and use port 0 for LOAD writes only.

Verification
REQ-021 SHALL cover: start with N=4, patches 0x1..0x4 presented back-to-back, out_ready=1 -> writes at addr0=0..3, then out_patch=0x1..0x4 on consecutive cycles, then done=1.
REQ-022 SHALL cover: N=3 with out_ready toggling 1,0,0,1,... -> no lost or duplicated patch, out_patch stable while stalled, csb1 low at most 2 reads ahead.
REQ-023 SHALL cover: start with N=0 -> done=1 next cycle, in_ready never 1, no memory access.
REQ-024 SHALL cover: N=600 -> clamped to 512, last write at addr0=511, 512 patches out.
REQ-025 SHALL cover: QPM_READBACK_EN defined, rb_valid=1 with rb_addr=2 during LOAD -> rb_ready=0; after LOAD -> rb_data_valid one cycle later with rb_data equal to patch 3; undefined -> rb_ready stays 0.
REQ-026 SHALL cover: rst pulsed mid-STREAM after 2 of 5 outputs -> all outputs at reset values the next cycle; a new start with N=2 completes correctly.
